// File: rtl/snake_input_pkg.sv
// Shared types and helpers for the buffered multi-player snake direction input.
// Contents:
//   dir_t       - 2-bit direction: 00 up, 01 left, 10 down, 11 right
//   key_hit_t   - decoded key: {hit, player, dir}
//   K_*         - scan codes for both players (E0 prefix already stripped)
//   opposite()  - the 180-degree reversal of a direction
//   key_to_dir()- maps a scan code to a player direction request
package snake_input_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        LEFT  = 2'b01,
        DOWN  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef struct packed {
        logic hit;
        logic player;
        dir_t dir;
    } key_hit_t;

    // Player 0: W/A/S/D
    localparam logic [7:0] K_P0_UP    = 8'h1D;
    localparam logic [7:0] K_P0_LEFT  = 8'h1C;
    localparam logic [7:0] K_P0_DOWN  = 8'h1B;
    localparam logic [7:0] K_P0_RIGHT = 8'h23;
    // Player 1: arrow keys
    localparam logic [7:0] K_P1_UP    = 8'h75;
    localparam logic [7:0] K_P1_LEFT  = 8'h6B;
    localparam logic [7:0] K_P1_DOWN  = 8'h72;
    localparam logic [7:0] K_P1_RIGHT = 8'h74;

    // Flipping the vertical/horizontal sense bit gives the reverse direction.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    function automatic key_hit_t key_to_dir(input logic [7:0] code);
        key_hit_t k;
        case (code)
            K_P0_UP:    k = '{hit: 1'b1, player: 1'b0, dir: UP};
            K_P0_LEFT:  k = '{hit: 1'b1, player: 1'b0, dir: LEFT};
            K_P0_DOWN:  k = '{hit: 1'b1, player: 1'b0, dir: DOWN};
            K_P0_RIGHT: k = '{hit: 1'b1, player: 1'b0, dir: RIGHT};
            K_P1_UP:    k = '{hit: 1'b1, player: 1'b1, dir: UP};
            K_P1_LEFT:  k = '{hit: 1'b1, player: 1'b1, dir: LEFT};
            K_P1_DOWN:  k = '{hit: 1'b1, player: 1'b1, dir: DOWN};
            K_P1_RIGHT: k = '{hit: 1'b1, player: 1'b1, dir: RIGHT};
            default:    k = '{hit: 1'b0, player: 1'b0, dir: UP};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// One player's direction request queue plus its current-direction register.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req         - a mapped make code for this player arrived this cycle
//   req_dir     - the requested direction
//   step        - game tick; pops the head into direction when non-empty
//   direction   - current snake direction (registered)
//   count       - queue occupancy (registered)
//   dropped     - one-cycle pulse after a request rejected for a full queue
module snake_dir_fifo
    import snake_input_pkg::*;
#(
    parameter int         DEPTH     = 4,
    parameter logic [1:0] RESET_DIR = 2'b00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req,
    input  dir_t                       req_dir,
    input  logic                       step,
    output dir_t                       direction,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       dropped
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    dir_t          mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;

    dir_t ref_dir_s;
    logic accept_s;
    logic full_s;
    logic push_s;
    logic drop_s;
    logic pop_s;

    // Request filtering against the most recent pending direction, and push/pop decisions.
    always_comb begin
        ref_dir_s = direction;
        if (count != CW'(0)) begin
            // Pointer arithmetic wraps naturally since DEPTH is a power of 2.
            ref_dir_s = mem_r[wr_ptr_r - PW'(1)];
        end else begin
            ref_dir_s = direction;
        end
        accept_s = req && (req_dir != ref_dir_s) && (req_dir != opposite(ref_dir_s));
        // Full check uses the pre-pop count, so a push into a full queue on a tick is dropped.
        full_s   = (count == CW'(DEPTH));
        push_s   = accept_s && !full_s;
        drop_s   = accept_s && full_s;
        // Pop sees pre-push contents, so an entry pushed into an empty queue waits a tick.
        pop_s    = step && (count != CW'(0));
    end

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= req_dir;
        end
    end

    // Pointers, occupancy, current direction and drop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r  <= PW'(0);
            rd_ptr_r  <= PW'(0);
            count     <= CW'(0);
            direction <= dir_t'(RESET_DIR);
            dropped   <= 1'b0;
        end else begin
            dropped <= drop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                direction <= mem_r[rd_ptr_r];
                rd_ptr_r  <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/snake_dir_queue.sv
// Buffered multi-player snake direction input. Decodes PS/2 make codes into
// per-player direction requests, queues them, and applies one per game tick.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   valid          - decoder strobe, one cycle per decoded code
//   makeBreak      - 1 = make (press), 0 = break (ignored)
//   outCode        - decoded scan code
//   step           - game-tick pulse
//   snakeDirection - bits [2p+1:2p] are player p's direction
//   queueCount     - per-player occupancy, $clog2(QUEUE_DEPTH+1) bits each
//   dropped        - per-player pulse after a request lost to a full queue
module snake_dir_queue
    import snake_input_pkg::*;
#(
    parameter int         NUM_PLAYERS = 2,
    parameter int         QUEUE_DEPTH = 4,
    parameter logic [1:0] RESET_DIR   = 2'b00
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          valid,
    input  logic                                          makeBreak,
    input  logic [7:0]                                    outCode,
    input  logic                                          step,
    output logic [2*NUM_PLAYERS-1:0]                      snakeDirection,
    output logic [NUM_PLAYERS*$clog2(QUEUE_DEPTH+1)-1:0]  queueCount,
    output logic [NUM_PLAYERS-1:0]                        dropped
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    key_hit_t key_s;

    // Decode the scan code once; each player picks out its own requests.
    always_comb begin
        key_s = key_to_dir(outCode);
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic          req_s;
        dir_t          dir_s;
        logic [CW-1:0] cnt_s;
        logic          drop_s;

        // With one player, player-1 codes simply match no instance.
        assign req_s = valid && makeBreak && key_s.hit && (key_s.player == 1'(p));

        snake_dir_fifo #(
            .DEPTH     (QUEUE_DEPTH),
            .RESET_DIR (RESET_DIR)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .req       (req_s),
            .req_dir   (key_s.dir),
            .step      (step),
            .direction (dir_s),
            .count     (cnt_s),
            .dropped   (drop_s)
        );

        assign snakeDirection[2*p +: 2] = dir_s;
        assign queueCount[CW*p +: CW]   = cnt_s;
        assign dropped[p]               = drop_s;
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue (2 players, depth 4): a queue-level
// behavioural model is compared against the DUT every cycle, with directed
// scenarios pinned by literal expectations, followed by randomized traffic.
module tb_snake_dir_queue;

    localparam int NP = 2;
    localparam int QD = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid = 1'b0;
    logic              makeBreak = 1'b0;
    logic [7:0]        outCode = 8'h00;
    logic              step = 1'b0;
    logic [2*NP-1:0]   snakeDirection;
    logic [NP*CW-1:0]  queueCount;
    logic [NP-1:0]     dropped;

    snake_dir_queue #(.NUM_PLAYERS(NP), .QUEUE_DEPTH(QD), .RESET_DIR(2'b00)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid          (valid),
        .makeBreak      (makeBreak),
        .outCode        (outCode),
        .step           (step),
        .snakeDirection (snakeDirection),
        .queueCount     (queueCount),
        .dropped        (dropped)
    );

    always #5 clk = ~clk;

    // Key tables indexed by direction value
    logic [7:0] p0_codes [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] p1_codes [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};

    // Model state
    logic [1:0] m_dir  [NP];
    logic [1:0] m_buf  [NP][QD];
    int         m_sz   [NP];
    logic [1:0] m_drop;
    bit         model_ok = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic check_all();
        logic [2*NP-1:0]  ed;
        logic [NP*CW-1:0] ec;
        if (model_ok) begin
            ed = {m_dir[1], m_dir[0]};
            ec = {3'(m_sz[1]), 3'(m_sz[0])};
            cmp("snakeDirection", 8'(snakeDirection), 8'(ed));
            cmp("queueCount", 8'(queueCount), 8'(ec));
            cmp("dropped", 8'(dropped), 8'(m_drop));
        end
    endtask

    task automatic model_update(input logic rst, input logic v, input logic mb,
                                input logic [7:0] code, input logic st);
        logic       hit;
        int         pl;
        logic [1:0] d;
        logic [1:0] refd;
        int         pre;
        logic       do_push;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_dir[p] = 2'b00;
                m_sz[p]  = 0;
            end
            m_drop   = 2'b00;
            model_ok = 1'b1;
        end else begin
            hit = 1'b0; pl = 0; d = 2'b00;
            for (int i = 0; i < 4; i++) begin
                if (code == p0_codes[i]) begin hit = 1'b1; pl = 0; d = 2'(i); end
                if (code == p1_codes[i]) begin hit = 1'b1; pl = 1; d = 2'(i); end
            end
            for (int p = 0; p < NP; p++) begin
                pre     = m_sz[p];
                refd    = (pre > 0) ? m_buf[p][pre-1] : m_dir[p];
                do_push = 1'b0;
                m_drop[p] = 1'b0;
                if (v && mb && hit && pl == p && d != refd && d != (refd ^ 2'b10)) begin
                    if (pre == QD) m_drop[p] = 1'b1;
                    else do_push = 1'b1;
                end
                if (st && pre > 0) begin
                    m_dir[p] = m_buf[p][0];
                    for (int k = 0; k < QD-1; k++) m_buf[p][k] = m_buf[p][k+1];
                    m_sz[p]--;
                end
                if (do_push) begin
                    m_buf[p][m_sz[p]] = d;
                    m_sz[p]++;
                end
            end
        end
    endtask

    // One clock: check current outputs, drive inputs, advance the model, wait an edge.
    task automatic cyc(input logic rst, input logic v, input logic mb,
                       input logic [7:0] code, input logic st);
        check_all();
        reset = rst; valid = v; makeBreak = mb; outCode = code; step = st;
        model_update(rst, v, mb, code, st);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, st);
    endtask

    task automatic key(input logic [7:0] code, input logic st);
        cyc(1'b0, 1'b1, 1'b1, code, st);
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Reset then idle steps
        idle(1'b1); idle(1'b1); idle(1'b1);
        cmp("rst_dir", 8'(snakeDirection), 8'h00);
        cmp("rst_cnt", 8'(queueCount), 8'h00);
        cmp("rst_drop", 8'(dropped), 8'h00);

        // Player 0: D then S, two ticks
        key(8'h23, 1'b0); key(8'h1B, 1'b0);
        cmp("p0_cnt2", 8'(queueCount[2:0]), 8'd2);
        idle(1'b1);
        cmp("p0_first", 8'(snakeDirection[1:0]), 8'h3);
        idle(1'b1);
        cmp("p0_second", 8'(snakeDirection[1:0]), 8'h2);
        cmp("p0_cnt0", 8'(queueCount[2:0]), 8'd0);

        // Reversal / duplicate filtering from dir 00
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        key(8'h1B, 1'b0);
        cmp("rev_ign", 8'(queueCount[2:0]), 8'd0);
        key(8'h1D, 1'b0);
        cmp("dup_ign", 8'(queueCount[2:0]), 8'd0);
        key(8'h1C, 1'b0);
        cmp("left_q", 8'(queueCount[2:0]), 8'd1);
        key(8'h23, 1'b0);
        cmp("tail_rev", 8'(queueCount[2:0]), 8'd1);
        idle(1'b1);
        cmp("left_dir", 8'(snakeDirection[1:0]), 8'h1);

        // Overflow
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        key(8'h1C, 1'b0); key(8'h1B, 1'b0); key(8'h23, 1'b0); key(8'h1D, 1'b0);
        cmp("full_cnt", 8'(queueCount[2:0]), 8'd4);
        key(8'h1C, 1'b0);
        cmp("drop_pulse", 8'(dropped), 8'h1);
        cmp("full_cnt2", 8'(queueCount[2:0]), 8'd4);
        idle(1'b0);
        cmp("drop_clear", 8'(dropped), 8'h0);
        idle(1'b1); cmp("replay0", 8'(snakeDirection[1:0]), 8'h1);
        idle(1'b1); cmp("replay1", 8'(snakeDirection[1:0]), 8'h2);
        idle(1'b1); cmp("replay2", 8'(snakeDirection[1:0]), 8'h3);
        idle(1'b1); cmp("replay3", 8'(snakeDirection[1:0]), 8'h0);

        // Player independence and break codes
        key(8'h74, 1'b0);
        cmp("p1_cnt", 8'(queueCount), 8'b001_000);
        cyc(1'b0, 1'b1, 1'b0, 8'h74, 1'b0);
        cmp("break_ign", 8'(queueCount), 8'b001_000);
        idle(1'b1);
        cmp("p1_dir", 8'(snakeDirection), 8'b11_00);

        // Push into empty queue on a tick: applied only on the next tick
        key(8'h1C, 1'b1);
        cmp("same_tick_dir", 8'(snakeDirection[1:0]), 8'h0);
        cmp("same_tick_cnt", 8'(queueCount[2:0]), 8'd1);
        idle(1'b1);
        cmp("next_tick_dir", 8'(snakeDirection[1:0]), 8'h1);

        // Reset with three queued requests
        key(8'h1D, 1'b0); key(8'h1C, 1'b0); key(8'h1B, 1'b0);
        cmp("pre_rst_cnt", 8'(queueCount[2:0]), 8'd3);
        cyc(1'b1, 1'b1, 1'b1, 8'h23, 1'b1);
        cmp("mid_rst_cnt", 8'(queueCount), 8'h00);
        cmp("mid_rst_dir", 8'(snakeDirection), 8'h00);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] code;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4)       code = p0_codes[$urandom_range(0, 3)];
            else if (sel < 8)  code = p1_codes[$urandom_range(0, 3)];
            else               code = 8'($urandom);
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 9) < 8),
                code,
                ($urandom_range(0, 9) < 2));
        end
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
